// File: rtl/wb_glitch_seq.sv
// Wishbone-controlled glitch pulse sequencer with per-channel alarm counters.
// One pulse per matching slot offset within each pass of a programmable period.
module wb_glitch_seq #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          N_SLOTS      = 8,
  parameter int          CTR_W        = 20,
  parameter int          N_CH         = 2,
  parameter int          CNT_W        = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [31:0]     i_wb_addr,
  input  logic [31:0]     i_wb_data,
  output logic            o_wb_ack,
  output logic            o_wb_stall,
  output logic [31:0]     o_wb_data,
  input  logic            trigger_i,
  input  logic [N_CH-1:0] alarm_i,
  output logic            glitch,
  output logic            busy,
  output logic [N_CH-1:0] alarm_latch
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [31:0]        off;
  logic               in_win;
  logic               req;
  logic               wr;
  logic [5:0]         word;
  logic               ctrl_wr;
  logic               cfg_ok;
  logic               cfg_wr;
  logic               abort;
  logic               arm;
  logic               clr;
  logic               unused;

  logic [CTR_W-1:0]   period;
  logic [N_SLOTS-1:0] slot_en;
  logic [CTR_W-1:0]   offset [N_SLOTS];
  logic               rep;
  logic               ext;
  logic [CTR_W-1:0]   ctr;
  logic [7:0]         pass_cnt;
  logic               pulse;
  logic               hit;
  logic               end_pass;

  logic [N_CH-1:0]    alarm_q;
  logic [CNT_W-1:0]   alarm_cnt [N_CH];
  logic [31:0]        rdata;

  assign off     = i_wb_addr - BASE_ADDRESS;
  assign in_win  = ~|off[31:8];
  assign req     = i_wb_cyc & i_wb_stb & in_win;
  assign wr      = req & i_wb_we;
  assign word    = off[7:2];
  assign ctrl_wr = wr && (word == 6'd0);
  assign cfg_ok  = (state == S_IDLE) || (state == S_DONE);
  assign cfg_wr  = wr & cfg_ok;
  assign abort   = ctrl_wr & i_wb_data[3];
  assign arm     = ctrl_wr & i_wb_data[0] & ~i_wb_data[3] & cfg_ok;
  assign clr     = ctrl_wr & i_wb_data[4];
  assign unused  = ^{i_wb_data, off[1:0]};

  assign o_wb_stall = 1'b0;
  assign glitch     = pulse & ~clk;
  assign end_pass   = (state == S_RUN) && (ctr == period);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < N_SLOTS; i++)
      if (slot_en[i] && (ctr == offset[i]))
        hit = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE:
          if (arm) state_nx = i_wb_data[2] ? S_WAIT : S_RUN;
        S_WAIT:
          if (trigger_i) state_nx = S_RUN;
        S_RUN:
          if (end_pass && !rep) state_nx = S_DONE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == S_WAIT) || (state == S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period  <= '0;
      slot_en <= '0;
      rep     <= 1'b0;
      ext     <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) offset[i] <= '0;
    end else if (cfg_wr) begin
      if (word == 6'd0) begin
        rep <= i_wb_data[1];
        ext <= i_wb_data[2];
      end
      if (word == 6'd2) period  <= i_wb_data[CTR_W-1:0];
      if (word == 6'd3) slot_en <= i_wb_data[N_SLOTS-1:0];
      for (int i = 0; i < N_SLOTS; i++)
        if (word == 6'(4 + i)) offset[i] <= i_wb_data[CTR_W-1:0];
    end
  end

  // Counter stays at 0 outside RUN so every entry into RUN starts a fresh pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr      <= '0;
      pulse    <= 1'b0;
      pass_cnt <= '0;
    end else begin
      ctr   <= (state == S_RUN && !end_pass && !abort) ? ctr + 1'b1 : '0;
      pulse <= (state == S_RUN) && hit && !abort;
      if (arm)
        pass_cnt <= '0;
      else if (end_pass && !abort)
        pass_cnt <= pass_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_q     <= '0;
      alarm_latch <= '0;
      for (int c = 0; c < N_CH; c++) alarm_cnt[c] <= '0;
    end else begin
      alarm_q <= alarm_i;
      for (int c = 0; c < N_CH; c++) begin
        if (clr) begin
          alarm_cnt[c]   <= '0;
          alarm_latch[c] <= 1'b0;
        end else if (alarm_i[c] && !alarm_q[c]) begin
          if (alarm_cnt[c] != '1) alarm_cnt[c] <= alarm_cnt[c] + 1'b1;
          alarm_latch[c] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      6'd1:    rdata = {16'd0, pass_cnt, 4'd0, ext, rep, state};
      6'd2:    rdata = 32'(period);
      6'd3:    rdata = 32'(slot_en);
      6'd48:   rdata = 32'(alarm_latch);
      default: rdata = '0;
    endcase
    for (int i = 0; i < N_SLOTS; i++)
      if (word == 6'(4 + i)) rdata = 32'(offset[i]);
    for (int c = 0; c < N_CH; c++)
      if (word == 6'(32 + c)) rdata = 32'(alarm_cnt[c]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack  <= req;
      o_wb_data <= (req && !i_wb_we) ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_wb_glitch_seq.sv
// Self-checking bench for wb_glitch_seq: directed scenarios plus
// randomized passes and alarm traffic against a pulse/edge model.
module tb_wb_glitch_seq;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic        i_wb_we = 1'b0;
  logic [31:0] i_wb_addr = '0;
  logic [31:0] i_wb_data = '0;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;
  logic        trigger_i = 1'b0;
  logic [1:0]  alarm_i = 2'b00;
  logic        glitch;
  logic        busy;
  logic [1:0]  alarm_latch;

  int n_assert = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int hi_viol = 0;
  int glog[$];
  int exp_q[$];
  int offs[8];

  wb_glitch_seq dut (
    .clk(clk),
    .reset(reset),
    .i_wb_cyc(i_wb_cyc),
    .i_wb_stb(i_wb_stb),
    .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr),
    .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack),
    .o_wb_stall(o_wb_stall),
    .o_wb_data(o_wb_data),
    .trigger_i(trigger_i),
    .alarm_i(alarm_i),
    .glitch(glitch),
    .busy(busy),
    .alarm_latch(alarm_latch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(posedge clk) begin
    #1;
    if (glitch === 1'b1) hi_viol++;
  end

  always @(negedge clk) begin
    #1;
    if (glitch === 1'b1) glog.push_back(cyc_n);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1;
    i_wb_addr = BASE + a; i_wb_data = d;
    @(posedge clk); #1;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    chk("wr_ack", o_wb_ack, 1'b1);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0;
    i_wb_addr = BASE + a;
    @(posedge clk); #1;
    i_wb_cyc = 0; i_wb_stb = 0;
    chk("rd_ack", o_wb_ack, 1'b1);
    d = o_wb_data;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse t cycles after the pass starts iff an enabled offset o <= P
  // equals t-1 (modulo the pass length when repeating).
  task automatic model(input int p, input int en, input bit rep,
                       input int last_t);
    bit h;
    exp_q.delete();
    for (int t = 1; t <= last_t; t++) begin
      h = 0;
      for (int i = 0; i < 8; i++)
        if (en[i] && offs[i] <= p &&
            (rep ? ((t - 1) % (p + 1)) == offs[i] : (t - 1) == offs[i]))
          h = 1;
      if (h) exp_q.push_back(t);
    end
  endtask

  task automatic check_log(input string tag, input int base);
    chk({tag, "_count"}, glog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < glog.size(); i++)
      chk({tag, "_at"}, glog[i] - base, exp_q[i]);
  endtask

  task automatic rand_pass(input int it);
    int p, en, a, e;
    bit rep;
    logic [31:0] d;
    p   = (it == 0) ? 0 : int'($urandom_range(1, 30));
    en  = int'($urandom_range(1, 255));
    rep = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) offs[i] = int'($urandom_range(0, p + 4));
    wr(8, p);
    wr(12, en);
    for (int i = 0; i < 8; i++) wr(16 + 4 * i, offs[i]);
    glog.delete();
    wr(0, rep ? 32'h3 : 32'h1);
    e = cyc_n;
    if (rep) begin
      a = int'($urandom_range(p + 2, 3 * p + 8));
      cycles(a - 1);
      wr(0, 32'h8);
      model(p, en, 1, a - 1);
    end else begin
      cycles(p + 6);
      model(p, en, 0, p + 6);
    end
    cycles(3);
    check_log("rand_pulses", e);
    rd(4, d);
    chk("rand_state", d[1:0], rep ? 2'd0 : 2'd3);
    if (!rep) chk("rand_pass_cnt", d[15:8], 8'd1);
  endtask

  initial begin
    logic [31:0] d;
    int e, tt;
    int cnt0, cnt1;
    logic [1:0] prev, v;

    cycles(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_glitch", glitch, 1'b0);
    chk("rst_ack", o_wb_ack, 1'b0);
    chk("rst_data", o_wb_data, 32'h0);
    chk("rst_latch", alarm_latch, 2'b00);
    reset = 1'b0;
    cycles(1);
    rd(4, d);
    chk("rst_status", d, 32'h0);
    rd(8, d);
    chk("rst_period", d, 32'h0);
    chk("stall", o_wb_stall, 1'b0);

    // single pass
    wr(8, 50);
    wr(12, 32'h05);
    wr(16, 3);
    wr(24, 7);
    glog.delete();
    wr(0, 32'h1);
    e = cyc_n;
    chk("s1_busy", busy, 1'b1);
    cycles(60);
    exp_q.delete();
    exp_q.push_back(4);
    exp_q.push_back(8);
    check_log("s1_pulses", e);
    rd(4, d);
    chk("s1_status", d, 32'h0000_0103);
    chk("s1_busy_done", busy, 1'b0);

    // repeat then abort
    wr(8, 9);
    wr(12, 32'h01);
    wr(16, 2);
    glog.delete();
    wr(0, 32'h3);
    e = cyc_n;
    cycles(34);
    wr(0, 32'h8);
    chk("s2_busy", busy, 1'b0);
    cycles(20);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(3 + 10 * k);
    check_log("s2_pulses", e);
    rd(4, d);
    chk("s2_state", d[1:0], 2'd0);
    chk("s2_pass", d[15:8], 8'd3);

    // external trigger
    wr(8, 20);
    wr(12, 32'h01);
    wr(16, 5);
    glog.delete();
    wr(0, 32'h5);
    chk("s3_busy", busy, 1'b1);
    cycles(20);
    rd(4, d);
    chk("s3_wait_state", d[1:0], 2'd1);
    chk("s3_ext_bit", d[3], 1'b1);
    chk("s3_no_glitch", glog.size(), 0);
    trigger_i = 1'b1;
    @(posedge clk); #1;
    trigger_i = 1'b0;
    tt = cyc_n;
    cycles(30);
    exp_q.delete();
    exp_q.push_back(6);
    check_log("s3_pulses", tt);
    rd(4, d);
    chk("s3_done", d[1:0], 2'd3);

    // write protect during RUN
    wr(8, 30);
    wr(12, 32'h01);
    wr(16, 4);
    glog.delete();
    wr(0, 32'h1);
    e = cyc_n;
    wr(16, 99);
    cycles(35);
    exp_q.delete();
    exp_q.push_back(5);
    check_log("s4_pulses", e);
    rd(16, d);
    chk("s4_offset_kept", d, 32'd4);

    // randomized passes
    for (int it = 0; it < 5; it++) rand_pass(it);

    // alarms
    for (int k = 0; k < 3; k++) begin
      alarm_i[1] = 1'b1;
      cycles(1);
      alarm_i[1] = 1'b0;
      cycles(2);
    end
    alarm_i[0] = 1'b1;
    cycles(10);
    alarm_i[0] = 1'b0;
    cycles(1);
    rd(32'h84, d);
    chk("al_cnt1", d, 32'd3);
    rd(32'h80, d);
    chk("al_cnt0", d, 32'd1);
    rd(32'hC0, d);
    chk("al_latch_reg", d, 32'h3);
    chk("al_latch_port", alarm_latch, 2'b11);
    alarm_i[0] = 1'b1;
    wr(0, 32'h10);
    rd(32'h80, d);
    chk("al_clr_cnt0", d, 32'd0);
    rd(32'h84, d);
    chk("al_clr_cnt1", d, 32'd0);
    rd(32'hC0, d);
    chk("al_clr_latch", d, 32'h0);
    chk("al_clr_port", alarm_latch, 2'b00);

    // random alarm traffic, model counts rising edges
    prev = alarm_i;
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 40; k++) begin
      v = 2'($urandom_range(0, 3));
      if (v[0] && !prev[0]) cnt0++;
      if (v[1] && !prev[1]) cnt1++;
      prev = v;
      alarm_i = v;
      cycles(1);
    end
    rd(32'h80, d);
    chk("al_rnd_cnt0", d, cnt0);
    rd(32'h84, d);
    chk("al_rnd_cnt1", d, cnt1);
    chk("al_rnd_latch", alarm_latch, {cnt1 != 0, cnt0 != 0});

    // bus edges
    rd(32'h40, d);
    chk("bus_unmapped_data", d, 32'h0);
    cycles(1);
    chk("bus_ack_one_cycle", o_wb_ack, 1'b0);
    chk("bus_data_idle", o_wb_data, 32'h0);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0;
    i_wb_addr = BASE + 32'h100;
    @(posedge clk); #1;
    i_wb_cyc = 0; i_wb_stb = 0;
    chk("bus_oow_ack", o_wb_ack, 1'b0);
    cycles(1);
    chk("bus_oow_ack2", o_wb_ack, 1'b0);

    // reset mid-RUN
    wr(8, 20);
    wr(12, 32'h01);
    wr(16, 5);
    glog.delete();
    wr(0, 32'h1);
    cycles(2);
    reset = 1'b1;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_glitch", glitch, 1'b0);
    cycles(10);
    chk("mr_no_pulse", glog.size(), 0);
    reset = 1'b0;
    cycles(1);
    rd(4, d);
    chk("mr_status", d, 32'h0);
    rd(16, d);
    chk("mr_offset", d, 32'h0);

    chk("glitch_high_phase", hi_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
